// File: rtl/multicycle_memory.sv
// multicycle_memory: single-port 18-bit memory responder for the multicycle calculator core.
// Instructions and data share one array. Each request is serviced after LATENCY clock edges
// and acknowledged with a four-phase enable/ready handshake.
//
// Parameters:
//   DEPTH   - number of 18-bit words (power of two, 2..2^18)
//   LATENCY - clock edges from request accept to ready (1..15)
//
// Ports:
//   clk             - clock, rising edge
//   reset           - synchronous, active-high
//   memoryEnable    - request / hold
//   memoryReadWrite - 1 = read, 0 = write (sampled at accept)
//   memoryAddress   - word address (sampled at accept)
//   memoryData      - bidirectional data; write data sampled at accept, read data driven
//                     only while responding to a read
//   memoryReady     - access complete; read data valid while high
//   memoryError     - address out of range, valid while memoryReady is high
//
// Build option: define MEMORY_BOUNDS_CHECK_EN to flag addresses >= DEPTH (writes dropped,
// reads return zero). Without it the address wraps modulo DEPTH and memoryError is 0.
module multicycle_memory #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memoryEnable,
  input  logic        memoryReadWrite,
  input  logic [17:0] memoryAddress,
  inout  wire  [17:0] memoryData,
  output logic        memoryReady,
  output logic        memoryError
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRespond, StRelease} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [17:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [17:0] wdata_q, wdata_d;
  logic [17:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        enter;
  logic        in_range;
  logic        drive;
  logic [AW-1:0] idx;

  logic [17:0] mem [DEPTH];

  assign idx = addr_q[AW-1:0];

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, addr_q} < 19'(DEPTH));
`else
  // Upper address bits are intentionally ignored: the address wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^addr_q;
  assign in_range    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      addr_q  <= 18'd0;
      rw_q    <= 1'b0;
      wdata_q <= 18'd0;
      rdata_q <= 18'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never reset; a write is committed only on the edge entering StRespond.
  always_ff @(posedge clk) begin
    if (!reset && enter && !rw_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    enter   = 1'b0;

    case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (memoryEnable) begin
          addr_d  = memoryAddress;
          rw_d    = memoryReadWrite;
          wdata_d = memoryData;
          count_d = 4'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (count_q == 4'd0) begin
          state_d = StRespond;
          enter   = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      StRespond: begin
        // Holding enable keeps us here; only a deassert re-arms the handshake.
        if (!memoryEnable) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = 4'd0;
        err_d   = 1'b0;
      end
    endcase

    if (enter) begin
      err_d = ~in_range;
      if (rw_q) begin
        rdata_d = in_range ? mem[idx] : 18'h0;
      end
    end
  end

  assign memoryReady = (state_q == StRespond);
  assign drive       = memoryReady && rw_q;
  assign memoryData  = drive ? rdata_q : 18'bz;

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign memoryError = memoryReady && err_q;
`else
  logic unused_err;
  assign unused_err  = err_q;
  assign memoryError = 1'b0;
`endif

endmodule
